// File: rtl/sisc_fetch.sv
// SISC instruction fetch unit: owns PC and IR and reads instruction memory
// over a request/acknowledge handshake on behalf of the control FSM.
module sisc_fetch #(
    parameter int                   ADDR_W = 16,
    parameter int                   DATA_W = 32,
    parameter logic [ADDR_W-1:0]    RST_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic              pc_rel,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_done,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        OP_HLT  = 4'hF;

    state_t              state_r,  state_s;
    logic [ADDR_W-1:0]   pc_r,     pc_s;
    logic [DATA_W-1:0]   ir_r,     ir_s;
    logic                rd_r,     rd_s;
    logic                done_r,   done_s;
    logic                busy_r,   busy_s;
    logic                halted_r, halted_s;
    logic                pend_r,   pend_s;
    logic [ADDR_W-1:0]   tgt_r,    tgt_s;
    logic                hold_r,   hold_s;
    logic [ADDR_W-1:0]   br_tgt_s;

    // Branch target: br_addr is already ADDR_W wide, so sign extension is a
    // no-op and a modulo-2^ADDR_W add gives the relative target directly.
    always_comb begin
        if (pc_rel) begin
            br_tgt_s = pc_r + br_addr;
        end else begin
            br_tgt_s = br_addr;
        end
    end

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        ir_s     = ir_r;
        rd_s     = rd_r;
        done_s   = 1'b0;
        busy_s   = busy_r;
        halted_s = halted_r;
        pend_s   = pend_r;
        tgt_s    = tgt_r;
        hold_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_r) begin
                    // Deferred fetch after a same-cycle redirect; a branch
                    // arriving now is kept pending so imem_addr stays put.
                    state_s = ST_REQ;
                    rd_s    = 1'b1;
                    busy_s  = 1'b1;
                    if (pc_load) begin
                        pend_s = 1'b1;
                        tgt_s  = br_tgt_s;
                    end else begin
                        pend_s = pend_r;
                    end
                end else if (pc_load) begin
                    pc_s = br_tgt_s;
                    if (fetch_req) begin
                        hold_s = 1'b1;
                        busy_s = 1'b1;
                    end else begin
                        hold_s = 1'b0;
                    end
                end else if (fetch_req) begin
                    state_s = ST_REQ;
                    rd_s    = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    ir_s   = imem_rdata;
                    rd_s   = 1'b0;
                    busy_s = 1'b0;
                    done_s = 1'b1;
                    pend_s = 1'b0;
                    if (pc_load) begin
                        pc_s = br_tgt_s;
                    end else if (pend_r) begin
                        pc_s = tgt_r;
                    end else begin
                        pc_s = pc_r + PC_ONE;
                    end
                    if (imem_rdata[31:28] == OP_HLT) begin
                        state_s  = ST_HALT;
                        halted_s = 1'b1;
                    end else begin
                        state_s  = ST_IDLE;
                    end
                end else if (pc_load) begin
                    pend_s = 1'b1;
                    tgt_s  = br_tgt_s;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                state_s  = ST_IDLE;
                rd_s     = 1'b0;
                busy_s   = 1'b0;
                halted_s = 1'b0;
                pend_s   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r  <= ST_IDLE;
            pc_r     <= RST_PC;
            ir_r     <= {DATA_W{1'b0}};
            rd_r     <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
            pend_r   <= 1'b0;
            tgt_r    <= {ADDR_W{1'b0}};
            hold_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            ir_r     <= ir_s;
            rd_r     <= rd_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
            halted_r <= halted_s;
            pend_r   <= pend_s;
            tgt_r    <= tgt_s;
            hold_r   <= hold_s;
        end
    end

    // PC only moves outside REQ or on the ack edge, so the PC register
    // doubles as the stable read address.
    assign imem_rd    = rd_r;
    assign imem_addr  = pc_r;
    assign ir         = ir_r;
    assign opcode     = ir_r[31:28];
    assign mm         = ir_r[27:24];
    assign pc         = pc_r;
    assign fetch_done = done_r;
    assign busy       = busy_r;
    assign halted     = halted_r;

endmodule

// File: doc/sisc_fetch.md
# sisc_fetch

Instruction fetch unit for the SISC computer: holds the program counter (PC) and instruction register (IR), and reads instruction memory through a request/acknowledge handshake. It sits directly upstream of the control FSM and supplies the `opcode` and `mm` fields that the FSM decodes. The FSM starts each fetch and signals branch redirects; this block reports completion back to it.

## Interface
- `ADDR_W`, 16, PC and instruction-memory address width
- `DATA_W`, 32, instruction width; field positions below are fixed for 32
- `RST_PC`, 0, PC value after reset
- `clk`  in  1  system clock, rising-edge active
- `rst_f`  in  1  reset; one clock; reset is asynchronous and active-low
- `fetch_req`  in  1  one-cycle start pulse from the control FSM in its fetch state
- `pc_load`  in  1  branch-taken pulse; redirects the PC
- `pc_rel`  in  1  with `pc_load`: 1 means PC-relative, 0 means absolute
- `br_addr`  in  ADDR_W  branch target or signed offset
- `imem_rd`  out  1  memory read request
- `imem_addr`  out  ADDR_W  read address; stable while `imem_rd`=1
- `imem_rdata`  in  DATA_W  instruction word; valid in the `imem_ack` cycle
- `imem_ack`  in  1  read complete
- `ir`  out  DATA_W  current instruction
- `opcode`  out  4  `ir[31:28]`
- `mm`  out  4  `ir[27:24]`
- `pc`  out  ADDR_W  address of the next instruction
- `fetch_done`  out  1  one-cycle pulse after the IR updates
- `busy`  out  1  a fetch is outstanding
- `halted`  out  1  HLT (opcode 15) has been fetched

## Operation
- The block has three states: IDLE, REQ and HALT. All outputs are registered.
- **IDLE, then `fetch_req`=1 (not halted):** go to REQ. Drive `imem_rd`=1 and `imem_addr`=`pc`, and raise `busy`.
- **REQ, then `imem_ack`=1:**
  - `ir` <= `imem_rdata`.
  - `pc` <= `pc`+1, modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
  - `imem_rd` and `busy` drop; `fetch_done` pulses for one cycle.
  - Next state is HALT if `imem_rdata[31:28]`=15, otherwise IDLE.
- **REQ without ack:** hold the request. `imem_rd` and `imem_addr` stay unchanged indefinitely; there is no timeout.
- **Branch in IDLE (`pc_load`=1):**
  - Absolute: `pc` <= `br_addr`.
  - Relative: `pc` <= `pc` + sign-extended `br_addr`, modulo 2^ADDR_W. `pc` here already points past the branch instruction.
- **Branch during REQ:** latch the target as a pending redirect. On the ack edge the PC takes the target instead of `pc`+1; the fetched instruction still loads into `ir`. A second `pc_load` in the same REQ overwrites the pending target.
- **`fetch_req` and `pc_load` in the same IDLE cycle:** apply the redirect first. The fetch is held one cycle and then issued from the new PC, so `imem_addr` equals the target.
- **`fetch_req` while `busy`=1:** ignored; no queueing.
- **HALT:** `fetch_req` and `pc_load` are ignored, `halted`=1, and `ir` keeps the HLT word. Only reset leaves HALT.
- **Reset (asynchronous, mid-fetch included):**
  - State returns to IDLE, `pc`=RST_PC and `ir`=0 (NOOP).
  - `imem_rd`, `busy`, `fetch_done` and `halted` go to 0, and any pending redirect is cleared.
  - An ack that arrives after reset in IDLE is ignored.

## Timing
- `imem_rd` rises on the edge after `fetch_req` is sampled.
- An ack can arrive in the first request cycle. Minimum latency from the `fetch_req` edge to `fetch_done`=1 is therefore 2 cycles; with N wait cycles it is 2+N.
- `ir`, `opcode`, `mm`, `pc` and `fetch_done` all update on the same edge. The control FSM samples `opcode` in decode, one cycle after fetch.
- `pc_load` is sampled on rising edges only. In IDLE its effect is visible on `pc` on the next edge.
- The IDLE collision case adds exactly 1 cycle of latency.
- `imem_addr` is X-free and equals `pc` whenever `imem_rd`=0.

## Test plan
- **Reset and basic fetch:** release `rst_f` with RST_PC=0, memory[0]=0x81230000, pulse `fetch_req`, ack in the first cycle. Required: `imem_rd` high for 1 cycle with `imem_addr`=0, `ir`=0x81230000, `opcode`=8, `mm`=1, `pc`=1, a single `fetch_done` pulse 2 cycles after `fetch_req`.
- **Wait states:** ack delayed 3 cycles. Required: `imem_rd` and `imem_addr` held for 4 cycles, `busy`=1 throughout, `fetch_done` at cycle 5, extra `fetch_req` pulses during `busy` ignored.
- **Branches:**
  - With `pc`=0x0010 in IDLE, `pc_load`, `pc_rel`=1, `br_addr`=0xFFFC: `pc`=0x000C.
  - Absolute with `br_addr`=0x0200: `pc`=0x0200.
  - From `pc`=0xFFFF a fetch leaves `pc`=0x0000.
- **Redirect during REQ / collision:**
  - `pc_load` to 0x0040 during a stalled fetch of address 5: `ir` gets word 5 and `pc`=0x0040.
  - Same-cycle `fetch_req`+`pc_load`=0x0080: `imem_addr`=0x0080.
- **Halt and mid-fetch reset:**
  - Fetch 0xF0000000: `halted`=1, and later `fetch_req` produces no `imem_rd`.
  - Assert `rst_f`=0 mid-REQ: `imem_rd`=0 immediately, `pc`=RST_PC, `ir`=0, `halted`=0.
